// File: rtl/capture_pkg.sv
// Shared types for the multi-channel capture controller.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } state_t;

    typedef enum logic {
        TRIG_OR  = 1'b0,
        TRIG_AND = 1'b1
    } trig_mode_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; also exposes the wrapped next value.
module mod_counter #(
    parameter int MOD = 384,
    parameter int W   = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt
);

    assign count_nxt = (count == W'(MOD - 1)) ? '0 : count + W'(1);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/capture_cntrl_mc.sv
// Capture controller: circular RAM write addressing, masked OR/AND trigger,
// pre-trigger depth enforcement and readout pointers for the channel sample RAMs.
module capture_cntrl_mc
    import capture_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt_smpl,
    input  logic              run,
    input  logic              abort,
    input  logic              clr_capture_done,
    input  logic [LOG2-1:0]   trig_pos,
    input  logic [NUM_CH-1:0] trig_mask,
    input  logic              trig_mode,
    input  logic [NUM_CH-1:0] ch_trig,
    input  logic              prot_en,
    input  logic              prot_trig,
    output logic              we,
    output logic [LOG2-1:0]   waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [LOG2-1:0]   start_addr,
    output logic [LOG2-1:0]   trig_addr
);

    localparam logic [LOG2-1:0] TP_MAX      = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   ENTRIES_EXT = (LOG2 + 1)'(ENTRIES);

    state_t state, state_nxt;

    logic [LOG2-1:0] tp_q;
    logic [LOG2-1:0] tp_in;
    logic [LOG2-1:0] pre_cnt;
    logic [LOG2:0]   post_cnt;
    logic [LOG2:0]   post_cnt_inc;
    logic [LOG2:0]   post_target;
    logic [LOG2-1:0] waddr_nxt;

    logic trig_hit, and_hit, or_hit;
    logic start_run, set_armed, hit_accept, finish, clr_flags, pre_inc, post_inc;

    assign tp_in        = (trig_pos > TP_MAX) ? TP_MAX : trig_pos;
    assign post_cnt_inc = post_cnt + (LOG2 + 1)'(1);
    assign post_target  = ENTRIES_EXT - {1'b0, tp_q};

    // An empty mask in AND mode must never fire, hence the |trig_mask qualifier.
    assign and_hit  = (&(ch_trig | ~trig_mask)) & (|trig_mask);
    assign or_hit   = |(ch_trig & trig_mask);
    assign trig_hit = ((trig_mode_t'(trig_mode) == TRIG_AND) ? and_hit : or_hit)
                    | (prot_en & prot_trig);

    assign we = wrt_smpl & ~abort & ((state == FILL) | (state == ARMED) | (state == POST));

    mod_counter #(
        .MOD (ENTRIES),
        .W   (LOG2)
    ) u_waddr (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_run),
        .inc       (we),
        .count     (waddr),
        .count_nxt (waddr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        start_run  = 1'b0;
        set_armed  = 1'b0;
        hit_accept = 1'b0;
        finish     = 1'b0;
        clr_flags  = 1'b0;
        pre_inc    = 1'b0;
        post_inc   = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
            clr_flags = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        start_run = 1'b1;
                        if (tp_in == '0) begin
                            state_nxt = ARMED;
                            set_armed = 1'b1;
                        end else begin
                            state_nxt = FILL;
                        end
                    end
                end
                FILL: begin
                    if (wrt_smpl) begin
                        pre_inc = 1'b1;
                        if (pre_cnt + LOG2'(1) == tp_q) begin
                            state_nxt = ARMED;
                            set_armed = 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        hit_accept = 1'b1;
                        state_nxt  = POST;
                        // A write in the hit cycle is already the first post-trigger sample.
                        if (wrt_smpl) begin
                            post_inc = 1'b1;
                            if (post_cnt_inc == post_target) begin
                                finish    = 1'b1;
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                POST: begin
                    if (wrt_smpl) begin
                        post_inc = 1'b1;
                        if (post_cnt_inc == post_target) begin
                            finish    = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (clr_capture_done) begin
                        state_nxt = IDLE;
                        clr_flags = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    clr_flags = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_q         <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            start_addr   <= '0;
            trig_addr    <= '0;
        end else begin
            if (clr_flags) begin
                armed        <= 1'b0;
                triggered    <= 1'b0;
                capture_done <= 1'b0;
            end
            if (start_run) begin
                tp_q     <= tp_in;
                pre_cnt  <= '0;
                post_cnt <= '0;
            end
            if (pre_inc) begin
                pre_cnt <= pre_cnt + LOG2'(1);
            end
            if (set_armed) begin
                armed <= 1'b1;
            end
            if (hit_accept) begin
                triggered <= 1'b1;
                trig_addr <= waddr;
            end
            if (post_inc) begin
                post_cnt <= post_cnt_inc;
            end
            if (finish) begin
                start_addr   <= waddr_nxt;
                capture_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_cntrl_mc.sv
// Self-checking bench for capture_cntrl_mc: a behavioural capture model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_capture_cntrl_mc;

    localparam int NUM_CH  = 5;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic              clk;
    logic              rst;
    logic              wrt_smpl;
    logic              run;
    logic              abort;
    logic              clr_capture_done;
    logic [LOG2-1:0]   trig_pos;
    logic [NUM_CH-1:0] trig_mask;
    logic              trig_mode;
    logic [NUM_CH-1:0] ch_trig;
    logic              prot_en;
    logic              prot_trig;
    logic              we;
    logic [LOG2-1:0]   waddr;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic [LOG2-1:0]   start_addr;
    logic [LOG2-1:0]   trig_addr;

    int n_checks = 0;
    int n_errors = 0;

    capture_cntrl_mc #(
        .NUM_CH  (NUM_CH),
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wrt_smpl         (wrt_smpl),
        .run              (run),
        .abort            (abort),
        .clr_capture_done (clr_capture_done),
        .trig_pos         (trig_pos),
        .trig_mask        (trig_mask),
        .trig_mode        (trig_mode),
        .ch_trig          (ch_trig),
        .prot_en          (prot_en),
        .prot_trig        (prot_trig),
        .we               (we),
        .waddr            (waddr),
        .armed            (armed),
        .triggered        (triggered),
        .capture_done     (capture_done),
        .start_addr       (start_addr),
        .trig_addr        (trig_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The capture is described as "writes since run", a pre-trigger quota and a
    // post-trigger quota; the ring position is just the write count modulo ENTRIES.
    bit m_running, m_done, m_armed, m_trig;
    int m_tp, m_pre, m_post, m_addr, m_trig_addr, m_start_addr;

    function automatic bit model_hit();
        int sel;
        bit ch_fire;
        sel = int'(ch_trig & trig_mask);
        if (trig_mode) ch_fire = (trig_mask != 0) && (sel == int'(trig_mask));
        else           ch_fire = (sel != 0);
        return ch_fire || (prot_en && prot_trig);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running = 0; m_done = 0; m_armed = 0; m_trig = 0;
            m_tp = 0; m_pre = 0; m_post = 0; m_addr = 0; m_trig_addr = 0; m_start_addr = 0;
        end else if (abort) begin
            m_running = 0; m_done = 0; m_armed = 0; m_trig = 0;
        end else if (m_running) begin
            int wa;
            bit hit;
            wa  = m_addr;
            hit = m_armed && !m_trig && model_hit();
            if (wrt_smpl) m_addr = (m_addr + 1) % ENTRIES;
            if (!m_armed) begin
                if (wrt_smpl) begin
                    m_pre++;
                    if (m_pre == m_tp) m_armed = 1;
                end
            end else if (!m_trig) begin
                if (hit) begin
                    m_trig = 1;
                    m_trig_addr = wa;
                    if (wrt_smpl) m_post++;
                end
            end else if (wrt_smpl) begin
                m_post++;
            end
            if (m_trig && m_post == ENTRIES - m_tp) begin
                m_running = 0;
                m_done = 1;
                m_start_addr = m_addr;
            end
        end else if (m_done) begin
            if (clr_capture_done) begin
                m_done = 0; m_armed = 0; m_trig = 0;
            end
        end else if (run) begin
            m_running = 1;
            m_tp = (int'(trig_pos) > ENTRIES - 1) ? ENTRIES - 1 : int'(trig_pos);
            m_addr = 0; m_pre = 0; m_post = 0;
            m_armed = (m_tp == 0);
        end
    end

    always @(negedge clk) begin
        check("m_we",           we,           32'(wrt_smpl && m_running && !abort && !rst));
        check("m_waddr",        waddr,        32'(m_addr));
        check("m_armed",        armed,        32'(m_armed));
        check("m_triggered",    triggered,    32'(m_trig));
        check("m_capture_done", capture_done, 32'(m_done));
        check("m_trig_addr",    trig_addr,    32'(m_trig_addr));
        check("m_start_addr",   start_addr,   32'(m_start_addr));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wrt_smpl = 0; run = 0; abort = 0; clr_capture_done = 0; ch_trig = '0; prot_trig = 0;
    endtask

    task automatic writes(input int n);
        wrt_smpl = 1;
        repeat (n) tick();
        wrt_smpl = 0;
    endtask

    task automatic start(input logic [LOG2-1:0] tp);
        trig_pos = tp;
        run = 1;
        tick();
        run = 0;
    endtask

    task automatic pulse_ch(input logic [NUM_CH-1:0] v);
        ch_trig = v;
        tick();
        ch_trig = '0;
    endtask

    task automatic clear_done();
        clr_capture_done = 1;
        tick();
        clr_capture_done = 0;
    endtask

    task automatic write_until_done(input int budget);
        int k;
        k = 0;
        wrt_smpl = 1;
        while (!capture_done && k < budget) begin
            tick();
            k++;
        end
        wrt_smpl = 0;
        if (!capture_done) check("done_timeout", 0, 1);
    endtask

    task automatic scenario_basic(input string tag);
        trig_mode = 0; trig_mask = 5'b00010; prot_en = 0;
        start(9'd100);
        writes(250);
        check({tag, "_armed"}, armed, 1);
        pulse_ch(5'b00010);
        check({tag, "_trig"}, triggered, 1);
        check({tag, "_trig_addr"}, trig_addr, 250);
        writes(283);
        check({tag, "_not_done"}, capture_done, 0);
        writes(1);
        check({tag, "_done"}, capture_done, 1);
        check({tag, "_start_addr"}, start_addr, 150);
        check({tag, "_waddr"}, waddr, 150);
        wrt_smpl = 1;
        #1;
        check({tag, "_we_after_done"}, we, 0);
        tick();
        wrt_smpl = 0;
        check({tag, "_waddr_hold"}, waddr, 150);
    endtask

    initial begin
        quiet();
        trig_pos = '0; trig_mask = '0; trig_mode = 0; prot_en = 0;
        rst = 1;
        #23;
        check("reset_waddr", waddr, 0);
        check("reset_flags", {29'd0, armed, triggered, capture_done}, 0);
        check("reset_we", we, 0);
        @(negedge clk);
        rst = 0;
        tick();

        // 1: basic OR-mode capture
        scenario_basic("s1");
        clear_done();
        check("s1_clr", {armed, triggered, capture_done}, 0);

        // 2: trigger during fill is ignored
        start(9'd100);
        writes(50);
        pulse_ch(5'b00010);
        check("s2_early_ignored", triggered, 0);
        writes(49);
        check("s2_not_armed_99", armed, 0);
        writes(1);
        check("s2_armed_100", armed, 1);
        pulse_ch(5'b00010);
        check("s2_trig", triggered, 1);
        check("s2_trig_addr", trig_addr, 100);
        write_until_done(400);
        check("s2_start_addr", start_addr, 0);
        clear_done();

        // 3 + 5: AND mode, empty mask, protocol trigger, abort in POST
        trig_mode = 1; trig_mask = 5'b10100;
        start(9'd0);
        check("s3_armed_tp0", armed, 1);
        pulse_ch(5'b00100);
        check("s3_and_partial", triggered, 0);
        pulse_ch(5'b10100);
        check("s3_and_full", triggered, 1);
        writes(10);
        abort = 1; wrt_smpl = 1;
        #1;
        check("s5_we_abort", we, 0);
        tick();
        abort = 0; wrt_smpl = 0;
        check("s5_flags", {armed, triggered, capture_done}, 0);
        check("s5_waddr_held", waddr, 10);
        trig_mask = 5'b00000;
        start(9'd0);
        check("s5_restart_waddr", waddr, 0);
        pulse_ch(5'b11111);
        check("s3_and_empty_mask", triggered, 0);
        prot_en = 1; prot_trig = 1;
        tick();
        prot_trig = 0; prot_en = 0;
        check("s3_prot", triggered, 1);
        abort = 1; run = 1;
        tick();
        abort = 0; run = 0;
        tick();
        check("s5_abort_beats_run", armed, 0);

        // 4: tp = 0 full post window, then clamped trig_pos
        trig_mode = 0; trig_mask = 5'b00001;
        start(9'd0);
        writes(17);
        pulse_ch(5'b00001);
        check("s4_trig_addr", trig_addr, 17);
        writes(383);
        check("s4_not_done", capture_done, 0);
        writes(1);
        check("s4_done", capture_done, 1);
        check("s4_start_addr", start_addr, 17);
        clear_done();
        start(9'd500);
        writes(382);
        check("s4_clamp_not_armed", armed, 0);
        writes(1);
        check("s4_clamp_armed", armed, 1);
        ch_trig = 5'b00001; wrt_smpl = 1;
        tick();
        ch_trig = '0; wrt_smpl = 0;
        check("s4_clamp_done", capture_done, 1);
        check("s4_clamp_trig_addr", trig_addr, 383);
        check("s4_clamp_start", start_addr, 0);
        clear_done();

        // 6: asynchronous reset mid-fill
        trig_mask = 5'b00010;
        start(9'd100);
        writes(30);
        wrt_smpl = 1;
        #3 rst = 1;
        #1;
        check("s6_rst_waddr", waddr, 0);
        check("s6_rst_we", we, 0);
        check("s6_rst_flags", {armed, triggered, capture_done}, 0);
        wrt_smpl = 0;
        tick();
        #2 rst = 0;
        tick();
        scenario_basic("s6");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/capture_cntrl_mc.md
Name: capture_cntrl_mc

Overview:
Parametrised multi-channel capture controller for the logic-analyzer digital core. It generates write enable and circular write address for all channel sample RAMs, and combines per-channel and protocol triggers under a channel mask with OR/AND mode. It enforces a programmable pre-trigger depth and reports where the capture starts and where the trigger sample sits for readout. It sits between the trigger sources, the cmd_cfg register block and the channel RAMs.

Parameters:
NUM_CH, 5, number of channel trigger inputs
ENTRIES, 384, RAM depth in samples; need not be a power of 2 (12288 on DE-0)
LOG2, 9, address width, ceil(log2(ENTRIES))

Ports:
clk  in  1  system clock (100MHz)
rst  in  1  reset, asynchronous, active-high
wrt_smpl  in  1  sample-write strobe from decimator timing
run  in  1  start pulse; honoured only in IDLE
abort  in  1  cancel capture from any state
clr_capture_done  in  1  pulse; DONE -> IDLE
trig_pos  in  LOG2  pre-trigger sample count
trig_mask  in  NUM_CH  channel participation mask
trig_mode  in  1  0 = OR of masked channels, 1 = AND of masked channels
ch_trig  in  NUM_CH  per-channel trigger events
prot_en  in  1  enables protocol trigger
prot_trig  in  1  protocol trigger event
we  out  1  RAM write enable
waddr  out  LOG2  RAM write address
armed  out  1  pre-trigger depth satisfied, waiting for trigger
triggered  out  1  trigger accepted
capture_done  out  1  capture complete
start_addr  out  LOG2  address of oldest valid sample
trig_addr  out  LOG2  address of first post-trigger sample

Behaviour:
- Reset (async, rst=1): state IDLE; waddr, start_addr, trig_addr, internal counters = 0; armed, triggered, capture_done = 0. we = 0 while rst=1.
- Effective pre-trigger count tp = min(trig_pos, ENTRIES-1). It is latched on run and does not change mid-capture.
- we = wrt_smpl & (state is FILL, ARMED or POST) & ~abort. It is combinational, with no latency.
- waddr is registered. It advances by 1 on every write and wraps from ENTRIES-1 to 0.
- States:
  - IDLE: on run, clear waddr, pre_cnt and post_cnt, and go to FILL. If tp == 0, go directly to ARMED instead.
  - FILL: each write increments pre_cnt. When the write makes pre_cnt == tp, go to ARMED and set armed. Triggers are ignored.
  - ARMED: writes continue and overwrite circularly. Trigger hit = (trig_mode ? &(ch_trig | ~trig_mask) & |trig_mask : |(ch_trig & trig_mask)) | (prot_en & prot_trig). On a hit, go to POST, set triggered, and latch trig_addr = waddr. The sample written in the hit cycle, if any, is the first post sample.
  - POST: each write increments post_cnt. On the write that makes post_cnt == ENTRIES - tp, latch start_addr = wrapped next waddr, go to DONE and set capture_done. we stops from the next cycle.
  - DONE: armed and triggered hold. On clr_capture_done, go to IDLE and clear all flags.
- AND mode with trig_mask == 0 never triggers on channels.
- run in any state other than IDLE is ignored. run and abort in the same cycle: abort wins.
- abort in any state: next state IDLE, flags cleared, waddr held.
- clr_capture_done outside DONE is ignored.

Decomposition:
- capture_pkg holds the state enum (IDLE, FILL, ARMED, POST, DONE) and the trig_mode_t enum (TRIG_OR, TRIG_AND).
- One sub-module, mod_counter, parametrised on MOD and W. It has clr and inc inputs, a wrap-around at MOD-1, and a registered count. It is used for waddr.
- pre_cnt and post_cnt are simple counters inside the block.

Test Plan:
1. tp=100, OR mode, mask=5'b00010, ch_trig[1] pulsed between writes after 250 writes -> triggered; done after 284 further writes; trig_addr=250, start_addr=150, capture_done=1, we=0 afterwards.
2. tp=100, ch_trig[1] pulsed after 50 writes -> ignored; armed rises on the 100th write; a later trigger is accepted.
3. AND mode, mask=5'b10100: ch_trig=5'b00100 -> no trigger; ch_trig=5'b10100 -> triggered next cycle. prot_en=1 with prot_trig alone also triggers.
4. tp=0 -> armed the cycle after run; trigger at waddr=17 -> 384 post writes; start_addr=trig_addr=17. trig_pos=500 -> clamped to 383: 1 post write.
5. abort during POST -> IDLE next cycle, we=0 in the abort cycle, flags 0; a new run restarts at waddr=0.
6. rst asserted mid-FILL, not clock-aligned -> all outputs 0 immediately; run after release behaves as in scenario 1.
